// File: rtl/imem_loader.sv
// imem_loader: boot loader that streams a length-prefixed little-endian byte image into imem.
// Optional build macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte checked before DONE.
module imem_loader #(
  parameter int  MEM_DEPTH = 256,
  localparam int ADDR_W    = $clog2(MEM_DEPTH),
  localparam int CNT_W     = $clog2(MEM_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_rst,
  output logic [CNT_W-1:0]  words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
`ifdef LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } state_t;

  state_t             state, state_next;
  logic               xfer;
  logic [15:0]        hdr_len;
  logic               hdr_bad;
  logic [7:0]         len_lo;
  logic [ADDR_W-1:0]  last_idx;
  logic [ADDR_W-1:0]  word_idx;
  logic [1:0]         byte_idx;
  logic [23:0]        word_buf;
  logic               last_byte;
  logic               last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum_acc;
`endif

  assign xfer      = rx_valid & rx_ready;
  assign hdr_len   = {rx_data, len_lo};
  assign hdr_bad   = (hdr_len == 16'd0) || (32'(hdr_len) > 32'(MEM_DEPTH));
  assign last_byte = (byte_idx == 2'd3);
  assign last_word = (word_idx == last_idx);

  // Status flags are pure decodes of the state so done/cpu_rst flip on the
  // same edge that launches the final word's write strobe.
  assign done    = (state == DONE);
  assign error   = (state == ERROR);
  assign cpu_rst = (state != DONE);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_next = state;
    rx_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: if (start) state_next = HDR0;
      HDR0: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_next = HDR1;
      end
      HDR1: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_next = hdr_bad ? ERROR : DATA;
      end
      DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && last_byte && last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_next = (rx_data == csum_acc) ? DONE : ERROR;
      end
`endif
      DONE, ERROR: if (start) state_next = HDR0;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_lo       <= '0;
      last_idx     <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      we           <= 1'b0;
      waddr        <= '0;
      wdata        <= '0;
      words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_acc     <= '0;
`endif
    end else begin
      we <= 1'b0;
      // A start outside a load rewinds the image pointers; xfer is never
      // high in those states, so this cannot collide with the byte path.
      if (start && !busy) begin
        word_idx     <= '0;
        byte_idx     <= '0;
        words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum_acc     <= '0;
`endif
      end
      if (xfer) begin
        case (state)
          HDR0: len_lo   <= rx_data;
          HDR1: last_idx <= ADDR_W'(hdr_len - 16'd1);
          DATA: begin
            byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_acc <= csum_acc ^ rx_data;
`endif
            case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                we           <= 1'b1;
                waddr        <= word_idx;
                wdata        <= {rx_data, word_buf};
                word_idx     <= word_idx + ADDR_W'(1);
                words_loaded <= words_loaded + CNT_W'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven bench for imem_loader, plus hand sequences for
// errors, restarts, mid-load reset and the optional checksum (LOADER_CHECKSUM_EN).
module tb_imem_loader;

  localparam int MEM_DEPTH = 256;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);
  localparam int CNT_W     = $clog2(MEM_DEPTH + 1);

  logic              clk;
  logic              reset;
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_rst;
  logic [CNT_W-1:0]  words_loaded;

  imem_loader #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .cpu_rst      (cpu_rst),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       data;
    logic             exp_we;
    logic [7:0]       exp_waddr;
    logic [31:0]      exp_wdata;
    logic [CNT_W-1:0] exp_wl;
    logic             exp_busy;
    logic             exp_done;
    logic             exp_cpu_rst;
  } vec_t;

  vec_t        vecs[10];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  exp_csum;
`endif

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      wr_addr_q.push_back(8'(waddr));
      wr_data_q.push_back(wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic w, input logic [7:0] a,
                              input logic [31:0] wd, input int wl, input logic b,
                              input logic dn, input logic cr);
    vec_t v;
    v.data = d; v.exp_we = w; v.exp_waddr = a; v.exp_wdata = wd;
    v.exp_wl = CNT_W'(wl); v.exp_busy = b; v.exp_done = dn; v.exp_cpu_rst = cr;
    return v;
  endfunction

  // Called at a negedge; returns at the negedge right after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit sent = 1'b0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 100 && !sent; i++) begin
      if (rx_ready === 1'b1) sent = 1'b1;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    if (!sent) check("rx_ready timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_stream(input int max_gap, input int poke_at, input string tag);
    for (int i = 0; i < 10; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (i == poke_at) pulse_start();
      send_byte(vecs[i].data, gap);
      check($sformatf("%s row%0d we", tag, i), we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        check($sformatf("%s row%0d waddr", tag, i), waddr, vecs[i].exp_waddr);
        check($sformatf("%s row%0d wdata", tag, i), wdata, vecs[i].exp_wdata);
      end
      check($sformatf("%s row%0d words_loaded", tag, i), words_loaded, vecs[i].exp_wl);
      check($sformatf("%s row%0d busy", tag, i), busy, vecs[i].exp_busy);
      check($sformatf("%s row%0d rx_ready", tag, i), rx_ready, vecs[i].exp_busy);
      check($sformatf("%s row%0d done", tag, i), done, vecs[i].exp_done);
      check($sformatf("%s row%0d cpu_rst", tag, i), cpu_rst, vecs[i].exp_cpu_rst);
    end
  endtask

  task automatic load_image(input int max_gap, input int poke_at, input string tag);
    run_stream(max_gap, poke_at, tag);
`ifdef LOADER_CHECKSUM_EN
    send_byte(exp_csum, 0);
    check({tag, " csum done"}, done, 1'b1);
    check({tag, " csum cpu_rst"}, cpu_rst, 1'b0);
`endif
  endtask

  task automatic check_writes(input string tag);
    @(negedge clk);
    check({tag, " write count"}, wr_addr_q.size(), 32'd2);
    if (wr_addr_q.size() >= 2) begin
      check({tag, " w0 addr"}, wr_addr_q[0], 32'd0);
      check({tag, " w0 data"}, wr_data_q[0], 32'h0000_0013);
      check({tag, " w1 addr"}, wr_addr_q[1], 32'd1);
      check({tag, " w1 data"}, wr_data_q[1], 32'h0010_0093);
    end
  endtask

  initial begin
    int bad;
    vecs[0] = mk(8'h02, 0, 8'd0, 32'h0, 0, 1, 0, 1);
    vecs[1] = mk(8'h00, 0, 8'd0, 32'h0, 0, 1, 0, 1);
    vecs[2] = mk(8'h13, 0, 8'd0, 32'h0, 0, 1, 0, 1);
    vecs[3] = mk(8'h00, 0, 8'd0, 32'h0, 0, 1, 0, 1);
    vecs[4] = mk(8'h00, 0, 8'd0, 32'h0, 0, 1, 0, 1);
    vecs[5] = mk(8'h00, 1, 8'd0, 32'h0000_0013, 1, 1, 0, 1);
    vecs[6] = mk(8'h93, 0, 8'd0, 32'h0, 1, 1, 0, 1);
    vecs[7] = mk(8'h00, 0, 8'd0, 32'h0, 1, 1, 0, 1);
    vecs[8] = mk(8'h10, 0, 8'd0, 32'h0, 1, 1, 0, 1);
`ifdef LOADER_CHECKSUM_EN
    vecs[9] = mk(8'h00, 1, 8'd1, 32'h0010_0093, 2, 1, 0, 1);
    exp_csum = 8'h00;
    for (int i = 2; i < 10; i++) exp_csum = exp_csum ^ vecs[i].data;
`else
    vecs[9] = mk(8'h00, 1, 8'd1, 32'h0010_0093, 2, 0, 1, 0);
`endif

    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    check("reset cpu_rst", cpu_rst, 1'b1);
    check("reset rx_ready", rx_ready, 1'b0);
    check("reset we", we, 1'b0);
    check("reset waddr", waddr, 32'd0);
    check("reset wdata", wdata, 32'd0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset error", error, 1'b0);
    check("reset words_loaded", words_loaded, 32'd0);
    reset = 1'b0;

    // Idle with a pending byte: nothing consumed, nothing written.
    rx_valid = 1'b1; rx_data = 8'hAA; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (cpu_rst !== 1'b1 || rx_ready !== 1'b0 || we !== 1'b0) bad++;
    end
    rx_valid = 1'b0;
    check("idle 20 cycles bad samples", bad, 32'd0);
    check("idle write count", wr_addr_q.size(), 32'd0);

    // Back-to-back image.
    pulse_start();
    check("start busy", busy, 1'b1);
    load_image(0, -1, "b2b");
    check_writes("b2b");
    check("b2b done sticky", done, 1'b1);

    // Restart from DONE with random gaps.
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    check("restart cpu_rst", cpu_rst, 1'b1);
    check("restart done", done, 1'b0);
    check("restart words_loaded", words_loaded, 32'd0);
    load_image(5, -1, "gaps");
    check_writes("gaps");

    // Start pulse mid-load must be ignored.
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    load_image(0, 3, "midstart");
    check_writes("midstart");

    // Oversized image (N=257), then recover.
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("n257 error", error, 1'b1);
    check("n257 busy", busy, 1'b0);
    check("n257 rx_ready", rx_ready, 1'b0);
    check("n257 cpu_rst", cpu_rst, 1'b1);
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (5) @(negedge clk);
    rx_valid = 1'b0;
    check("n257 no writes", wr_addr_q.size(), 32'd0);
    check("n257 error sticky", error, 1'b1);
    pulse_start();
    check("recover error cleared", error, 1'b0);
    load_image(0, -1, "recover");
    check_writes("recover");
    check("recover error", error, 1'b0);

    // Zero-length image is rejected.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("n0 error", error, 1'b1);

    // Full-depth image header (N=256) is accepted.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    check("n256 error", error, 1'b0);
    check("n256 busy", busy, 1'b1);

    // Reset mid-load after one word has been written.
    wr_addr_q.delete(); wr_data_q.delete();
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(vecs[i].data, 0);
    check("midreset pre words_loaded", words_loaded, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset busy", busy, 1'b0);
    check("midreset rx_ready", rx_ready, 1'b0);
    check("midreset words_loaded", words_loaded, 32'd0);
    check("midreset cpu_rst", cpu_rst, 1'b1);
    check("midreset writes kept", wr_addr_q.size(), 32'd1);

    // Start and reset together: reset wins.
    start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    check("start+reset busy", busy, 1'b0);
    @(negedge clk);
    check("start+reset still idle", busy, 1'b0);

    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    load_image(0, -1, "reload");
    check_writes("reload");

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: words stay written, CPU held in reset.
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    run_stream(0, -1, "badcsum");
    send_byte(8'h00, 0);
    check("badcsum error", error, 1'b1);
    check("badcsum done", done, 1'b0);
    check("badcsum cpu_rst", cpu_rst, 1'b1);
    check_writes("badcsum");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
